mux4_reg: RTL and testbench



---
 rtl/mux4_pkg.sv | 30 +++
 rtl/mux4_reg_if.sv | 39 +++
 rtl/mux4_sel_decode.sv | 26 ++
 rtl/mux4_reg.sv | 75 +++++++
 tb/tb_mux4_reg.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/mux4_pkg.sv
// Shared types and helpers for the registered 4-to-1 selector.
package mux4_pkg;

  typedef enum logic [1:0] {
    SEL_A = 2'd0,
    SEL_B = 2'd1,
    SEL_C = 2'd2,
    SEL_D = 2'd3
  } sel_t;

  localparam int NUM_INPUTS = 4;

  function automatic logic [NUM_INPUTS-1:0] sel_onehot(input sel_t sel);
    logic [NUM_INPUTS-1:0] code;
    case (sel)
      SEL_A:   code = 4'b0001;
      SEL_B:   code = 4'b0010;
      SEL_C:   code = 4'b0100;
      SEL_D:   code = 4'b1000;
      default: code = 4'b0000;
    endcase
    return code;
  endfunction

  // Even-parity bit of a zero-extended word; zero padding does not change it.
  function automatic logic parity64(input logic [63:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/mux4_reg_if.sv
// Data/select/result bundle of mux4_reg; out_parity exists only with MUX4_REG_PARITY_EN.
interface mux4_reg_if #(
  parameter int WIDTH = 1
);

  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             s0;
  logic             s1;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic [1:0]       sel_q;
`ifdef MUX4_REG_PARITY_EN
  logic             out_parity;
`else
`endif

  modport master (
    output en, a, b, c, d, s0, s1,
    input  out, out_valid, sel_q
`ifdef MUX4_REG_PARITY_EN
    , input out_parity
`else
`endif
  );

  modport slave (
    input  en, a, b, c, d, s0, s1,
    output out, out_valid, sel_q
`ifdef MUX4_REG_PARITY_EN
    , output out_parity
`else
`endif
  );

endinterface

// File: rtl/mux4_sel_decode.sv
// Combinational 2-to-4 one-hot decode driving an AND-OR data selector.
module mux4_sel_decode
  import mux4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  sel_t             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] data
);

  logic [NUM_INPUTS-1:0] onehot_s;

  // Each one-hot bit gates its input; exactly one term survives the OR.
  always_comb begin
    onehot_s = sel_onehot(sel);
    data     = ({WIDTH{onehot_s[0]}} & a)
             | ({WIDTH{onehot_s[1]}} & b)
             | ({WIDTH{onehot_s[2]}} & c)
             | ({WIDTH{onehot_s[3]}} & d);
  end

endmodule

// File: rtl/mux4_reg.sv
// Registered 4-to-1 selector with load enable and one-cycle valid flag.
// Optional registered out_parity under macro MUX4_REG_PARITY_EN.
module mux4_reg
  import mux4_pkg::*;
#(
  parameter int          WIDTH     = 1,
  parameter logic [63:0] RESET_VAL = 64'd0
) (
  input logic        clk,
  input logic        rst,
  mux4_reg_if.slave  bus
);

  localparam logic [WIDTH-1:0] RESET_W = RESET_VAL[WIDTH-1:0];

  sel_t             sel_s;
  logic [WIDTH-1:0] sel_data_s;
  logic [WIDTH-1:0] out_r;
  logic             valid_r;
  sel_t             sel_q_r;

  assign sel_s = sel_t'({bus.s1, bus.s0});

  mux4_sel_decode #(
    .WIDTH (WIDTH)
  ) u_sel_decode (
    .sel  (sel_s),
    .a    (bus.a),
    .b    (bus.b),
    .c    (bus.c),
    .d    (bus.d),
    .data (sel_data_s)
  );

  // Capture the selected word and its select on enable; valid marks each load.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r   <= RESET_W;
      valid_r <= 1'b0;
      sel_q_r <= SEL_A;
    end else begin
      valid_r <= bus.en;
      if (bus.en) begin
        out_r   <= sel_data_s;
        sel_q_r <= sel_s;
      end else begin
        out_r   <= out_r;
        sel_q_r <= sel_q_r;
      end
    end
  end

  assign bus.out       = out_r;
  assign bus.out_valid = valid_r;
  assign bus.sel_q     = 2'(sel_q_r);

`ifdef MUX4_REG_PARITY_EN
  logic parity_r;

  // Parity tracks out exactly, including its reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_r <= parity64(64'(RESET_W));
    end else if (bus.en) begin
      parity_r <= parity64(64'(sel_data_s));
    end else begin
      parity_r <= parity_r;
    end
  end

  assign bus.out_parity = parity_r;
`else
`endif

endmodule

// File: tb/tb_mux4_reg.sv
// Directed bench for mux4_reg: an 8-bit instance and a 1-bit instance (RESET_VAL=1).
module tb_mux4_reg;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mux4_reg_if #(.WIDTH(8)) bus8 ();
  mux4_reg_if #(.WIDTH(1)) bus1 ();

  mux4_reg #(.WIDTH(8), .RESET_VAL(64'd0)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  mux4_reg #(.WIDTH(1), .RESET_VAL(64'd1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive8(input logic en, input logic [1:0] sel);
    bus8.en = en;
    bus8.s1 = sel[1];
    bus8.s0 = sel[0];
  endtask

  function automatic logic ref_sel1(input logic a, input logic b, input logic c, input logic d,
                                    input logic [1:0] sel);
    case (sel)
      2'b00:   return a;
      2'b01:   return b;
      2'b10:   return c;
      default: return d;
    endcase
  endfunction

  initial begin
    logic [1:0] rsel;
    logic       ra, rb, rc, rd, rexp;
    checks = 0;
    errors = 0;

    // Reset with enable asserted: reset must win.
    rst = 1'b1;
    bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.c = 8'hFF; bus8.d = 8'hFF;
    drive8(1'b1, 2'b00);
    bus1.a = 1'b0; bus1.b = 1'b0; bus1.c = 1'b0; bus1.d = 1'b0;
    bus1.en = 1'b1; bus1.s1 = 1'b1; bus1.s0 = 1'b1;
    tick();
    check("rst_out8", 64'(bus8.out), 64'h00);
    check("rst_valid8", 64'(bus8.out_valid), 64'd0);
    check("rst_selq8", 64'(bus8.sel_q), 64'd0);
    check("rst_out1", 64'(bus1.out), 64'd1);
    check("rst_valid1", 64'(bus1.out_valid), 64'd0);
    check("rst_selq1", 64'(bus1.sel_q), 64'd0);
`ifdef MUX4_REG_PARITY_EN
    check("rst_par8", 64'(bus8.out_parity), 64'd0);
    check("rst_par1", 64'(bus1.out_parity), 64'd1);
`else
`endif
    rst = 1'b0;
    bus1.en = 1'b0;

    // Full select sweep, back-to-back enables.
    bus8.a = 8'h11; bus8.b = 8'h22; bus8.c = 8'h33; bus8.d = 8'h44;
    drive8(1'b1, 2'b00); tick();
    check("sweep0_out", 64'(bus8.out), 64'h11);
    check("sweep0_valid", 64'(bus8.out_valid), 64'd1);
    check("sweep0_selq", 64'(bus8.sel_q), 64'd0);
    drive8(1'b1, 2'b01); tick();
    check("sweep1_out", 64'(bus8.out), 64'h22);
    check("sweep1_valid", 64'(bus8.out_valid), 64'd1);
    check("sweep1_selq", 64'(bus8.sel_q), 64'd1);
    drive8(1'b1, 2'b10); tick();
    check("sweep2_out", 64'(bus8.out), 64'h33);
    check("sweep2_valid", 64'(bus8.out_valid), 64'd1);
    check("sweep2_selq", 64'(bus8.sel_q), 64'd2);
    drive8(1'b1, 2'b11); tick();
    check("sweep3_out", 64'(bus8.out), 64'h44);
    check("sweep3_valid", 64'(bus8.out_valid), 64'd1);
    check("sweep3_selq", 64'(bus8.sel_q), 64'd3);

    // Hold: load 0x33, then change c and select with enable low.
    drive8(1'b1, 2'b10); tick();
    check("hold_load_out", 64'(bus8.out), 64'h33);
    bus8.c = 8'hAA;
    drive8(1'b0, 2'b11); tick();
    check("hold_out", 64'(bus8.out), 64'h33);
    check("hold_valid", 64'(bus8.out_valid), 64'd0);
    check("hold_selq", 64'(bus8.sel_q), 64'd2);
    tick();
    check("hold2_out", 64'(bus8.out), 64'h33);
    check("hold2_valid", 64'(bus8.out_valid), 64'd0);

    // Single enable pulse.
    bus8.b = 8'h5A;
    drive8(1'b1, 2'b01); tick();
    check("pulse_out", 64'(bus8.out), 64'h5A);
    check("pulse_valid", 64'(bus8.out_valid), 64'd1);
    check("pulse_selq", 64'(bus8.sel_q), 64'd1);
    drive8(1'b0, 2'b01); tick();
    check("pulse_after_valid", 64'(bus8.out_valid), 64'd0);
    check("pulse_after_out", 64'(bus8.out), 64'h5A);

`ifdef MUX4_REG_PARITY_EN
    bus8.d = 8'h07;
    drive8(1'b1, 2'b11); tick();
    check("par_d07", 64'(bus8.out_parity), 64'd1);
    bus8.a = 8'h03;
    drive8(1'b1, 2'b00); tick();
    check("par_a03", 64'(bus8.out_parity), 64'd0);
    drive8(1'b0, 2'b00);
`else
`endif

    // Reset again over a loaded value with enable high.
    rst = 1'b1;
    drive8(1'b1, 2'b01); tick();
    check("rst2_out8", 64'(bus8.out), 64'h00);
    check("rst2_valid8", 64'(bus8.out_valid), 64'd0);
    check("rst2_selq8", 64'(bus8.sel_q), 64'd0);
    rst = 1'b0;
    drive8(1'b0, 2'b00);

    // WIDTH=1 random selection, enable held high.
    for (int i = 0; i < 20; i++) begin
      ra = 1'($urandom_range(1, 0)); rb = 1'($urandom_range(1, 0));
      rc = 1'($urandom_range(1, 0)); rd = 1'($urandom_range(1, 0));
      rsel = 2'($urandom_range(3, 0));
      bus1.a = ra; bus1.b = rb; bus1.c = rc; bus1.d = rd;
      bus1.s1 = rsel[1]; bus1.s0 = rsel[0]; bus1.en = 1'b1;
      rexp = ref_sel1(ra, rb, rc, rd, rsel);
      tick();
      check($sformatf("rand%0d_out", i), 64'(bus1.out), 64'(rexp));
      check($sformatf("rand%0d_selq", i), 64'(bus1.sel_q), 64'(rsel));
      check($sformatf("rand%0d_valid", i), 64'(bus1.out_valid), 64'd1);
    end
    bus1.en = 1'b0;
    tick();
    check("rand_end_valid", 64'(bus1.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
